// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter with open-drain drive
module ps2_host_tx #(
  parameter int CLK_INHIBIT_CYCLES = 5000,
  parameter int START_SETUP_CYCLES = 50,
  parameter int FIRST_EDGE_TIMEOUT = 750000,
  parameter int XFER_TIMEOUT       = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code,
  output logic       rx_inhibit
);

  // Phase counter serves INHIBIT, START and WAIT_FIRST; transfer counter spans SEND..WAIT_IDLE.
  localparam int PH_MAX_A = (CLK_INHIBIT_CYCLES > START_SETUP_CYCLES) ? CLK_INHIBIT_CYCLES : START_SETUP_CYCLES;
  localparam int PH_MAX   = (PH_MAX_A > FIRST_EDGE_TIMEOUT) ? PH_MAX_A : FIRST_EDGE_TIMEOUT;
  localparam int PH_W     = $clog2(PH_MAX + 1);
  localparam int XF_W     = $clog2(XFER_TIMEOUT + 1);

  localparam logic [PH_W-1:0] INH_LAST   = PH_W'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0] START_LAST = PH_W'(START_SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0] FIRST_LAST = PH_W'(FIRST_EDGE_TIMEOUT - 1);
  localparam logic [XF_W-1:0] XF_LAST    = XF_W'(XFER_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_WAIT_FIRST, S_SEND, S_WAIT_ACK, S_WAIT_IDLE, S_ERROR
  } state_t;

  state_t          state_q;
  logic [9:0]      shift_q;
  logic [3:0]      bit_cnt_q;
  logic [PH_W-1:0] ph_cnt_q;
  logic [XF_W-1:0] xf_cnt_q;
  logic            clk_en_q, dat_en_q;
  logic            tx_ready_q, tx_done_q, tx_error_q, rx_inhibit_q;
  logic [1:0]      err_code_q;
  logic            clk_meta_q, clk_sync_q, clk_prev_q;
  logic            dat_meta_q, dat_sync_q;

  logic            clk_fall;
  logic [PH_W-1:0] ph_cnt_sat;
  logic [XF_W-1:0] xf_cnt_sat;

  assign PS2_CLK = clk_en_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_en_q ? 1'b0 : 1'bz;

  assign clk_fall   = clk_prev_q & ~clk_sync_q;
  assign ph_cnt_sat = (ph_cnt_q == '1) ? ph_cnt_q : ph_cnt_q + PH_W'(1);
  assign xf_cnt_sat = (xf_cnt_q == '1) ? xf_cnt_q : xf_cnt_q + XF_W'(1);

  assign tx_ready   = tx_ready_q;
  assign tx_done    = tx_done_q;
  assign tx_error   = tx_error_q;
  assign err_code   = err_code_q;
  assign rx_inhibit = rx_inhibit_q;

  // Two-flop synchronizers for both lines plus a delayed clock copy for fall detection.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= PS2_CLK;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= PS2_DAT;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Transfer FSM; all outputs and line enables are registered here.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      ph_cnt_q     <= '0;
      xf_cnt_q     <= '0;
      clk_en_q     <= 1'b0;
      dat_en_q     <= 1'b0;
      tx_ready_q   <= 1'b1;
      tx_done_q    <= 1'b0;
      tx_error_q   <= 1'b0;
      err_code_q   <= 2'b00;
      rx_inhibit_q <= 1'b0;
    end else begin
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tx_valid) begin
            shift_q      <= {1'b1, ~^tx_data, tx_data};
            ph_cnt_q     <= '0;
            clk_en_q     <= 1'b1;
            tx_ready_q   <= 1'b0;
            rx_inhibit_q <= 1'b1;
            err_code_q   <= 2'b00;
            state_q      <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (ph_cnt_q == INH_LAST) begin
            dat_en_q <= 1'b1;
            ph_cnt_q <= '0;
            state_q  <= S_START;
          end else begin
            ph_cnt_q <= ph_cnt_sat;
          end
        end
        S_START: begin
          if (ph_cnt_q == START_LAST) begin
            clk_en_q <= 1'b0;
            ph_cnt_q <= '0;
            state_q  <= S_WAIT_FIRST;
          end else begin
            ph_cnt_q <= ph_cnt_sat;
          end
        end
        S_WAIT_FIRST: begin
          if (clk_fall) begin
            dat_en_q  <= ~shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= 4'd1;
            xf_cnt_q  <= '0;
            state_q   <= S_SEND;
          end else if (ph_cnt_q == FIRST_LAST) begin
            clk_en_q   <= 1'b0;
            dat_en_q   <= 1'b0;
            tx_error_q <= 1'b1;
            err_code_q <= 2'b01;
            state_q    <= S_ERROR;
          end else begin
            ph_cnt_q <= ph_cnt_sat;
          end
        end
        S_SEND: begin
          xf_cnt_q <= xf_cnt_sat;
          if (clk_fall) begin
            // The tenth edge presents the stop bit, which releases DAT.
            dat_en_q  <= ~shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd9) state_q <= S_WAIT_ACK;
          end else if (xf_cnt_q == XF_LAST) begin
            dat_en_q   <= 1'b0;
            tx_error_q <= 1'b1;
            err_code_q <= 2'b10;
            state_q    <= S_ERROR;
          end
        end
        S_WAIT_ACK: begin
          xf_cnt_q <= xf_cnt_sat;
          if (clk_fall) begin
            if (!dat_sync_q) begin
              state_q <= S_WAIT_IDLE;
            end else begin
              tx_error_q <= 1'b1;
              err_code_q <= 2'b11;
              state_q    <= S_ERROR;
            end
          end else if (xf_cnt_q == XF_LAST) begin
            tx_error_q <= 1'b1;
            err_code_q <= 2'b10;
            state_q    <= S_ERROR;
          end
        end
        S_WAIT_IDLE: begin
          xf_cnt_q <= xf_cnt_sat;
          if (clk_sync_q && dat_sync_q) begin
            tx_done_q    <= 1'b1;
            tx_ready_q   <= 1'b1;
            rx_inhibit_q <= 1'b0;
            state_q      <= S_IDLE;
          end else if (xf_cnt_q == XF_LAST) begin
            tx_error_q <= 1'b1;
            err_code_q <= 2'b10;
            state_q    <= S_ERROR;
          end
        end
        S_ERROR: begin
          clk_en_q     <= 1'b0;
          dat_en_q     <= 1'b0;
          tx_ready_q   <= 1'b1;
          rx_inhibit_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          clk_en_q     <= 1'b0;
          dat_en_q     <= 1'b0;
          tx_ready_q   <= 1'b1;
          rx_inhibit_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
